fifo_fill_ctrl: RTL

- Load/drain sequencer that sits directly upstream of a bank of ROWS shift-delay FIFOs (each DEPTH x BITS, shift on en, oldest entry visible on q).
- Fill phase: accepts a valid/ready word stream and shifts DEPTH words into each FIFO in turn, row 0 first.
- Drain phase: shifts all FIFOs together for DEPTH cycles so their q outputs stream to the downstream consumer, and flags those cycles valid.

---
 rtl/sa_pkg.sv | 27 ++
 rtl/fifo_fill_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the FIFO fill/drain sequencer, the FIFO bank it
// feeds and the downstream consumer array.
//   state_t    : sequencer state encoding (IDLE, FILL, DRAIN, DONE)
//   *_DEF      : default bank geometry (rows, entries per row, word width)
//   cnt_width  : counter width helper, never narrower than one bit
// ---------------------------------------------------------------------------
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int ROWS_DEF  = 8;
    localparam int DEPTH_DEF = 8;
    localparam int BITS_DEF  = 64;

    // $clog2(1) is 0, which would give a zero-width counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_fill_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_fill_ctrl
// Load/drain sequencer placed directly upstream of a bank of ROWS shift-delay
// FIFOs (DEPTH x BITS each). FILL shifts DEPTH accepted words into each row in
// turn, row 0 first; DRAIN then shifts every row together for DEPTH cycles so
// the oldest entries stream out on the FIFO q outputs.
//
// Ports:
//   clk         : clock
//   rst_n       : asynchronous active-low reset
//   start       : begin an operation (honoured only in IDLE)
//   in_data     : upstream write word
//   in_valid    : in_data is valid
//   in_ready    : block accepts in_data this cycle (state == FILL)
//   fifo_d      : data to every FIFO d input (registered)
//   fifo_en     : per-row shift enable (registered)
//   drain_valid : high exactly on the cycles fifo_en is all ones
//   busy        : high whenever not in IDLE
//   done        : one-cycle pulse after the last drain shift
// ---------------------------------------------------------------------------
module fifo_fill_ctrl
    import sa_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int BITS  = BITS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [BITS-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [BITS-1:0] fifo_d,
    output logic [ROWS-1:0] fifo_en,
    output logic            drain_valid,
    output logic            busy,
    output logic            done
);

    localparam int RW = cnt_width(ROWS);
    localparam int WW = cnt_width(DEPTH);

    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(DEPTH - 1);

    state_t          state_reg;
    logic [RW-1:0]   row_reg;
    logic [WW-1:0]   word_reg;
    logic [BITS-1:0] fifo_d_reg;
    logic [ROWS-1:0] fifo_en_reg;
    logic            drain_valid_reg;
    logic            done_reg;

    logic [ROWS-1:0] row_onehot;
    logic [WW-1:0]   word_next;
    logic            xfer;

    // One-hot decode of the row currently being filled.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_dec
            assign row_onehot[gi] = (row_reg == RW'(gi));
        end
    endgenerate

    assign word_next = (word_reg == WORD_LAST) ? '0 : word_reg + WW'(1);
    assign xfer      = in_valid && (state_reg == FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            row_reg         <= '0;
            word_reg        <= '0;
            fifo_d_reg      <= '0;
            fifo_en_reg     <= '0;
            drain_valid_reg <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            // Enables and pulses default low; fifo_d holds unless rewritten.
            fifo_en_reg     <= '0;
            drain_valid_reg <= 1'b0;
            done_reg        <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= FILL;
                        row_reg   <= '0;
                        word_reg  <= '0;
                    end
                end
                FILL: begin
                    if (xfer) begin
                        fifo_d_reg  <= in_data;
                        fifo_en_reg <= row_onehot;
                        word_reg    <= word_next;
                        if (word_reg == WORD_LAST) begin
                            if (row_reg == ROW_LAST) begin
                                row_reg   <= '0;
                                state_reg <= DRAIN;
                            end else begin
                                row_reg <= row_reg + RW'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    // The word counter enters at 0 and wraps back to 0 after
                    // DEPTH shifts; drain_valid_reg tells "not started" apart
                    // from "finished", so no extra counter bit is needed.
                    if (!drain_valid_reg || (word_reg != '0)) begin
                        fifo_en_reg     <= '1;
                        fifo_d_reg      <= '0;
                        drain_valid_reg <= 1'b1;
                        word_reg        <= word_next;
                    end else begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state_reg == FILL);
    assign busy        = (state_reg != IDLE);
    assign fifo_d      = fifo_d_reg;
    assign fifo_en     = fifo_en_reg;
    assign drain_valid = drain_valid_reg;
    assign done        = done_reg;

endmodule
